raizing_gcu_vcount: RTL and testbench



---
 rtl/raizing_gcu_vcount.sv | 102 ++++++++++
 tb/tb_raizing_gcu_vcount.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_gcu_vcount.sv
// GCU video counter block: sync-window flags, CPU status snapshot, frame counter
// and the vblank / raster interrupt latches.
module raizing_gcu_vcount (
  input  logic        clk,
  input  logic        reset,
  input  logic        pxl_cen,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        lhbl,
  input  logic        lvbl,
  input  logic [8:0]  hs_start,
  input  logic [8:0]  hs_end,
  input  logic [8:0]  vs_start,
  input  logic [8:0]  vs_end,
  input  logic        cpu_rd,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        irq_en,
  input  logic        raster_en,
  input  logic [8:0]  raster_line,
  input  logic        irq_ack,
  output logic        vblank_irq,
  output logic        raster_irq,
  output logic [7:0]  frame_cnt
);

  localparam logic [8:0] LINES_PER_FRAME = 9'd263;

  logic        hs_flag;
  logic        vs_flag;
  logic        lvbl_q;
  logic [8:0]  vpos_q;
  logic        lvbl_d;
  logic        raster_armed;
  logic        hs_win;
  logic        vs_win;
  logic [15:0] status;
  logic        vblank_edge;
  logic        raster_hit;
  logic        unused_lhbl;

  assign unused_lhbl = lhbl;

  // Windows are non-wrapping: an inverted or empty range never asserts.
  always_comb begin
    hs_win = (hs_start < hs_end) && (hpos >= hs_start) && (hpos < hs_end);
    vs_win = (vs_start < vs_end) && (vpos >= vs_start) && (vpos < vs_end);
    status = {hs_flag, vs_flag, ~lvbl_q, 4'b0000, vpos_q};
    vblank_edge = lvbl_d && !lvbl;
    raster_hit = pxl_cen && raster_en && raster_armed && (raster_line < LINES_PER_FRAME) &&
                 (vpos == raster_line) && (hpos == hs_start);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_flag <= 1'b0;
      vs_flag <= 1'b0;
      lvbl_q  <= 1'b1;
      vpos_q  <= 9'd0;
    end else if (pxl_cen) begin
      hs_flag <= hs_win;
      vs_flag <= vs_win;
      lvbl_q  <= lvbl;
      vpos_q  <= vpos;
    end
  end

  // The snapshot takes the registered status, so a coincident pixel update is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= 16'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= cpu_rd;
      if (cpu_rd) rd_data <= status;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvbl_d     <= 1'b1;
      frame_cnt  <= 8'd0;
      vblank_irq <= 1'b0;
    end else begin
      lvbl_d <= lvbl;
      if (vblank_edge) frame_cnt <= frame_cnt + 8'd1;
      vblank_irq <= (vblank_edge && irq_en) || (vblank_irq && !irq_ack);
    end
  end

  // Arming tracks the previous sampled dot, so hpos must leave hs_start before another hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raster_armed <= 1'b0;
      raster_irq   <= 1'b0;
    end else begin
      if (pxl_cen) raster_armed <= (hpos != hs_start);
      raster_irq <= raster_hit || (raster_irq && !irq_ack);
    end
  end

endmodule

// File: tb/tb_raizing_gcu_vcount.sv
// Directed self-checking bench for raizing_gcu_vcount.
module tb_raizing_gcu_vcount;

  logic        clk = 1'b0;
  logic        reset;
  logic        pxl_cen;
  logic [8:0]  hpos, vpos;
  logic        lhbl, lvbl;
  logic [8:0]  hs_start, hs_end, vs_start, vs_end;
  logic        cpu_rd;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        irq_en, raster_en;
  logic [8:0]  raster_line;
  logic        irq_ack;
  logic        vblank_irq, raster_irq;
  logic [7:0]  frame_cnt;

  int pass_count = 0;
  int check_count = 0;

  raizing_gcu_vcount dut (
    .clk(clk), .reset(reset), .pxl_cen(pxl_cen), .hpos(hpos), .vpos(vpos),
    .lhbl(lhbl), .lvbl(lvbl), .hs_start(hs_start), .hs_end(hs_end),
    .vs_start(vs_start), .vs_end(vs_end), .cpu_rd(cpu_rd), .rd_data(rd_data),
    .rd_valid(rd_valid), .irq_en(irq_en), .raster_en(raster_en),
    .raster_line(raster_line), .irq_ack(irq_ack), .vblank_irq(vblank_irq),
    .raster_irq(raster_irq), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [8:0] h, input logic [8:0] v);
    hpos = h;
    vpos = v;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
  endtask

  task automatic read_status(output logic [15:0] d);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    d = rd_data;
  endtask

  task automatic vblank_pulse();
    lvbl = 1'b1;
    tick();
    lvbl = 1'b0;
    tick();
  endtask

  // One dot per pxl_cen every 8 clk; the flag is read back right after its update.
  task automatic apply_stimulus_sweep(input bit window_valid, input string tag);
    logic [15:0] d;
    bit exp_flag;
    for (int h = 0; h < 432; h++) begin
      pixel(9'(h), 9'd10);
      read_status(d);
      exp_flag = window_valid && (h >= 325) && (h < 380);
      check_output(tag, 32'(d[15]), 32'(exp_flag));
      repeat (6) tick();
    end
  endtask

  task automatic raster_frame(output int hits, output int hit_v, output int hit_h);
    hits = 0;
    hit_v = -1;
    hit_h = -1;
    for (int v = 0; v < 263; v++) begin
      for (int h = 320; h <= 330; h++) begin
        pixel(9'(h), 9'(v));
        if (raster_irq) begin
          hits++;
          hit_v = v;
          hit_h = h;
          irq_ack = 1'b1;
          tick();
          irq_ack = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    int hits, hit_v, hit_h, total_hits;

    reset = 1'b1; pxl_cen = 1'b0; hpos = 9'd0; vpos = 9'd0; lhbl = 1'b1; lvbl = 1'b1;
    hs_start = 9'd325; hs_end = 9'd380; vs_start = 9'd0; vs_end = 9'd0;
    cpu_rd = 1'b0; irq_en = 1'b0; raster_en = 1'b0; raster_line = 9'd0; irq_ack = 1'b0;

    #2;
    check_output("reset_rd_data", 32'(rd_data), 32'h0);
    check_output("reset_rd_valid", 32'(rd_valid), 32'h0);
    check_output("reset_vblank_irq", 32'(vblank_irq), 32'h0);
    check_output("reset_raster_irq", 32'(raster_irq), 32'h0);
    check_output("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    read_status(d);
    check_output("post_reset_valid", 32'(rd_valid), 32'h1);
    check_output("post_reset_status", 32'(d), 32'h0000);
    tick();
    check_output("idle_valid_low", 32'(rd_valid), 32'h0);
    check_output("no_spurious_frame", 32'(frame_cnt), 32'h0);

    apply_stimulus_sweep(1'b1, "hs_window");
    hs_start = 9'd380; hs_end = 9'd325;
    apply_stimulus_sweep(1'b0, "hs_inverted");
    hs_start = 9'd325; hs_end = 9'd380;

    vs_start = 9'd232; vs_end = 9'd245; lvbl = 1'b0;
    pixel(9'd0, 9'd240);
    read_status(d);
    check_output("rd_valid_pulse", 32'(rd_valid), 32'h1);
    check_output("rd_data_snapshot", 32'(d), 32'h60F0);
    tick();
    check_output("rd_valid_drop", 32'(rd_valid), 32'h0);
    check_output("rd_data_hold", 32'(rd_data), 32'h60F0);
    check_output("first_frame_cnt", 32'(frame_cnt), 32'h1);
    check_output("no_irq_when_disabled", 32'(vblank_irq), 32'h0);

    cpu_rd = 1'b1; pxl_cen = 1'b1; vpos = 9'd241;
    tick();
    pxl_cen = 1'b0;
    check_output("b2b_first_valid", 32'(rd_valid), 32'h1);
    check_output("b2b_first_preupdate", 32'(rd_data), 32'h60F0);
    tick();
    cpu_rd = 1'b0;
    check_output("b2b_second_valid", 32'(rd_valid), 32'h1);
    check_output("b2b_second_fresh", 32'(rd_data), 32'h60F1);
    tick();
    check_output("b2b_valid_drop", 32'(rd_valid), 32'h0);

    lvbl = 1'b1;
    tick();
    check_output("vblank_idle", 32'(vblank_irq), 32'h0);
    irq_en = 1'b1; lvbl = 1'b0;
    tick();
    check_output("vblank_set", 32'(vblank_irq), 32'h1);
    check_output("vblank_frame_cnt", 32'(frame_cnt), 32'h2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_output("vblank_ack_clear", 32'(vblank_irq), 32'h0);
    lvbl = 1'b1;
    tick();
    lvbl = 1'b0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_output("vblank_set_wins", 32'(vblank_irq), 32'h1);
    check_output("vblank_frame_cnt3", 32'(frame_cnt), 32'h3);
    irq_en = 1'b0;
    tick();
    check_output("vblank_en_off_holds", 32'(vblank_irq), 32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_output("vblank_ack_clear2", 32'(vblank_irq), 32'h0);
    vblank_pulse();
    check_output("vblank_blocked", 32'(vblank_irq), 32'h0);
    check_output("frame_cnt4", 32'(frame_cnt), 32'h4);

    raster_en = 1'b1; raster_line = 9'd100;
    total_hits = 0;
    for (int f = 0; f < 2; f++) begin
      raster_frame(hits, hit_v, hit_h);
      total_hits += hits;
      check_output("raster_hits_per_frame", 32'(hits), 32'h1);
      check_output("raster_hit_line", 32'(hit_v), 32'd100);
      check_output("raster_hit_dot", 32'(hit_h), 32'd325);
    end
    check_output("raster_total_hits", 32'(total_hits), 32'h2);

    pixel(9'd324, 9'd100);
    pixel(9'd325, 9'd100);
    check_output("raster_single_set", 32'(raster_irq), 32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    pixel(9'd325, 9'd100);
    check_output("raster_no_rearm", 32'(raster_irq), 32'h0);
    pixel(9'd326, 9'd100);
    pixel(9'd325, 9'd100);
    check_output("raster_rearmed", 32'(raster_irq), 32'h1);
    raster_en = 1'b0;
    tick();
    check_output("raster_en_off_holds", 32'(raster_irq), 32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check_output("raster_ack_clear", 32'(raster_irq), 32'h0);

    raster_en = 1'b1; raster_line = 9'd300;
    raster_frame(hits, hit_v, hit_h);
    check_output("raster_300_frame", 32'(hits), 32'h0);
    pixel(9'd324, 9'd300);
    pixel(9'd325, 9'd300);
    check_output("raster_300_direct", 32'(raster_irq), 32'h0);

    for (int i = 0; i < 251; i++) vblank_pulse();
    check_output("frame_cnt_255", 32'(frame_cnt), 32'd255);
    vblank_pulse();
    check_output("frame_cnt_wrap", 32'(frame_cnt), 32'h0);

    irq_en = 1'b1;
    vblank_pulse();
    raster_line = 9'd100;
    pixel(9'd324, 9'd100);
    pixel(9'd325, 9'd100);
    check_output("pending_vblank", 32'(vblank_irq), 32'h1);
    check_output("pending_raster", 32'(raster_irq), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_vblank_clr", 32'(vblank_irq), 32'h0);
    check_output("async_raster_clr", 32'(raster_irq), 32'h0);
    check_output("async_frame_clr", 32'(frame_cnt), 32'h0);
    check_output("async_rd_data_clr", 32'(rd_data), 32'h0);
    lvbl = 1'b1; hpos = 9'd0;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_output("release_vblank_quiet", 32'(vblank_irq), 32'h0);
    check_output("release_raster_quiet", 32'(raster_irq), 32'h0);
    check_output("release_frame_cnt", 32'(frame_cnt), 32'h0);
    lvbl = 1'b0;
    tick();
    check_output("after_reset_first_frame", 32'(frame_cnt), 32'h1);
    check_output("after_reset_vblank", 32'(vblank_irq), 32'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #5000000;
    check_count++;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
